id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 16-bit MIPS pipeline. Sits directly upstream of the EX-stage ALU and drives its OPCODE, a and b inputs.
- Captures decoded operands and control, inserts bubbles on flush or load-use hazard, and holds on external stall.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB results, and raises a load-use stall request to the IF/ID stage.

---
 rtl/id_ex_stage_if.sv | 53 +++++
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID operands, downstream forwarding sources, and registered EX outputs.
// The master side is the decode/pipeline environment; the slave side is id_ex_stage.
interface id_ex_stage_if #(
  parameter int W  = 16,
  parameter int RW = 3
);
  logic          id_valid;
  logic [2:0]    id_opcode;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [W-1:0]  id_rs_data;
  logic [W-1:0]  id_rt_data;
  logic [W-1:0]  id_imm;
  logic          id_use_imm;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;

  logic          exmem_reg_write;
  logic [RW-1:0] exmem_rd;
  logic [W-1:0]  exmem_result;
  logic          memwb_reg_write;
  logic [RW-1:0] memwb_rd;
  logic [W-1:0]  memwb_result;

  logic [2:0]    alu_opcode;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic          ex_valid;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic [RW-1:0] ex_rd;
  logic [W-1:0]  ex_store_data;
  logic          load_use_stall;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_use_imm, id_reg_write, id_mem_read, id_mem_write,
           exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
    input  alu_opcode, alu_a, alu_b, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_rd, ex_store_data, load_use_stall
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_use_imm, id_reg_write, id_mem_read, id_mem_write,
           exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
    output alu_opcode, alu_a, alu_b, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_rd, ex_store_data, load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit MIPS pipeline: bubbles, stall hold, hazard detect.
// Define ID_EX_FORWARD_EN to build EX/MEM and MEM/WB forwarding; otherwise every RAW hazard stalls.
module id_ex_stage #(
  parameter int W  = 16,
  parameter int RW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic [2:0]    opcode;
`ifdef ID_EX_FORWARD_EN
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
`endif
    logic [RW-1:0] rd;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic [W-1:0]  imm;
    logic          use_imm;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d, id_cap;
  logic    uses_rt;
  logic    ex_hit;
  logic    load_use;
  logic [W-1:0] fwd_a;
  logic [W-1:0] fwd_b;
`ifndef ID_EX_FORWARD_EN
  logic    exmem_hit;
`endif

  always_comb begin
    id_cap           = '0;
    id_cap.valid     = bus.id_valid;
    id_cap.opcode    = bus.id_opcode;
`ifdef ID_EX_FORWARD_EN
    id_cap.rs        = bus.id_rs;
    id_cap.rt        = bus.id_rt;
`endif
    id_cap.rd        = bus.id_rd;
    id_cap.rs_data   = bus.id_rs_data;
    id_cap.rt_data   = bus.id_rt_data;
    id_cap.imm       = bus.id_imm;
    id_cap.use_imm   = bus.id_use_imm;
    id_cap.reg_write = bus.id_reg_write & bus.id_valid;
    id_cap.mem_read  = bus.id_mem_read  & bus.id_valid;
    id_cap.mem_write = bus.id_mem_write & bus.id_valid;
  end

  // rt counts as a source when it feeds the ALU or supplies store data.
  always_comb begin
    uses_rt  = !bus.id_use_imm || bus.id_mem_write;
    ex_hit   = (ex_q.rd != '0) &&
               ((ex_q.rd == bus.id_rs) || (uses_rt && (ex_q.rd == bus.id_rt)));
    load_use = bus.id_valid & ex_q.valid & ex_q.mem_read & ex_hit;
`ifndef ID_EX_FORWARD_EN
    exmem_hit = (bus.exmem_rd != '0) &&
                ((bus.exmem_rd == bus.id_rs) || (uses_rt && (bus.exmem_rd == bus.id_rt)));
    load_use  = load_use | (bus.id_valid &
                ((ex_q.valid & ex_q.reg_write & ex_hit) | (bus.exmem_reg_write & exmem_hit)));
`endif
  end

  always_comb begin
    ex_d = id_cap;
    if (flush)         ex_d = '0;
    else if (stall)    ex_d = ex_q;
    else if (load_use) ex_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

`ifdef ID_EX_FORWARD_EN
  // EX/MEM is checked first so the youngest result wins; r0 never forwards.
  always_comb begin
    fwd_a = ex_q.rs_data;
    if (bus.exmem_reg_write && (bus.exmem_rd == ex_q.rs) && (ex_q.rs != '0))
      fwd_a = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd == ex_q.rs) && (ex_q.rs != '0))
      fwd_a = bus.memwb_result;
    fwd_b = ex_q.rt_data;
    if (bus.exmem_reg_write && (bus.exmem_rd == ex_q.rt) && (ex_q.rt != '0))
      fwd_b = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd == ex_q.rt) && (ex_q.rt != '0))
      fwd_b = bus.memwb_result;
  end
`else
  always_comb begin
    fwd_a = ex_q.rs_data;
    fwd_b = ex_q.rt_data;
  end
`endif

  always_comb begin
    bus.alu_opcode    = '0;
    bus.alu_a         = '0;
    bus.alu_b         = '0;
    bus.ex_store_data = '0;
    if (ex_q.valid) begin
      bus.alu_opcode    = ex_q.opcode;
      bus.alu_a         = fwd_a;
      bus.alu_b         = ex_q.use_imm ? ex_q.imm : fwd_b;
      bus.ex_store_data = fwd_b;
    end
    bus.ex_valid       = ex_q.valid;
    bus.ex_reg_write   = ex_q.reg_write;
    bus.ex_mem_read    = ex_q.mem_read;
    bus.ex_mem_write   = ex_q.mem_write;
    bus.ex_rd          = ex_q.rd;
    bus.load_use_stall = load_use;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations follow the build selected by ID_EX_FORWARD_EN.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst, stall, flush;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.W(16), .RW(3)) bus ();

  id_ex_stage #(.W(16), .RW(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .stall(stall),
    .flush(flush),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] op,
                        input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                        input logic [15:0] rsd, input logic [15:0] rtd, input logic [15:0] imm,
                        input logic ui, input logic rw, input logic mr, input logic mw);
    bus.id_valid     = v;
    bus.id_opcode    = op;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_rs_data   = rsd;
    bus.id_rt_data   = rtd;
    bus.id_imm       = imm;
    bus.id_use_imm   = ui;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
  endtask

  task automatic set_fwd(input logic erw, input logic [2:0] erd, input logic [15:0] eres,
                         input logic mrw, input logic [2:0] mrd, input logic [15:0] mres);
    bus.exmem_reg_write = erw;
    bus.exmem_rd        = erd;
    bus.exmem_result    = eres;
    bus.memwb_reg_write = mrw;
    bus.memwb_rd        = mrd;
    bus.memwb_result    = mres;
  endtask

  initial begin
    // Reset wins over stall while ID presents a valid add r1=r2+r3.
    rst = 1'b1; stall = 1'b1; flush = 1'b0;
    set_id(1, 3'd0, 3'd2, 3'd3, 3'd1, 16'h0005, 16'h0007, 16'h0000, 0, 1, 0, 0);
    set_fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    tick; tick;
    check("rst_ex_valid",   bus.ex_valid,       0);
    check("rst_opcode",     bus.alu_opcode,     0);
    check("rst_alu_a",      bus.alu_a,          0);
    check("rst_alu_b",      bus.alu_b,          0);
    check("rst_ex_rd",      bus.ex_rd,          0);
    check("rst_store",      bus.ex_store_data,  0);
    check("rst_reg_write",  bus.ex_reg_write,   0);
    check("rst_lus",        bus.load_use_stall, 0);

    rst = 1'b0; stall = 1'b0;
    #1;
    check("add_lus", bus.load_use_stall, 0);
    tick;
    check("add_valid",     bus.ex_valid,      1);
    check("add_opcode",    bus.alu_opcode,    0);
    check("add_alu_a",     bus.alu_a,         16'h0005);
    check("add_alu_b",     bus.alu_b,         16'h0007);
    check("add_store",     bus.ex_store_data, 16'h0007);
    check("add_rd",        bus.ex_rd,         1);
    check("add_reg_write", bus.ex_reg_write,  1);
    check("add_mem_read",  bus.ex_mem_read,   0);

`ifdef ID_EX_FORWARD_EN
    // sub r4=r1-r2, r1 arrives from EX/MEM one cycle later.
    set_id(1, 3'd1, 3'd1, 3'd2, 3'd4, 16'h0099, 16'h0005, 16'h0000, 0, 1, 0, 0);
    #1;
    check("sub_lus", bus.load_use_stall, 0);
    tick;
    set_fwd(1, 3'd1, 16'h000C, 0, 3'd0, 16'h0);
    #1;
    check("sub_opcode", bus.alu_opcode, 1);
    check("sub_fwd_a",  bus.alu_a,      16'h000C);
    check("sub_alu_b",  bus.alu_b,      16'h0005);

    set_fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    set_id(1, 3'd2, 3'd2, 3'd0, 3'd5, 16'h0AAA, 16'h0BBB, 16'h0000, 0, 1, 0, 0);
    tick;
    set_fwd(1, 3'd2, 16'h1111, 1, 3'd2, 16'h2222);
    #1;
    check("prio_exmem_a", bus.alu_a, 16'h1111);
    check("prio_r0_b",    bus.alu_b, 16'h0BBB);
    set_fwd(0, 3'd2, 16'h1111, 1, 3'd2, 16'h2222);
    #1;
    check("prio_memwb_a", bus.alu_a, 16'h2222);
    set_id(1, 3'd2, 3'd0, 3'd0, 3'd5, 16'h0123, 16'h0456, 16'h0000, 0, 1, 0, 0);
    set_fwd(1, 3'd0, 16'h1111, 1, 3'd0, 16'h2222);
    tick;
    check("r0_no_fwd_a", bus.alu_a, 16'h0123);
    check("r0_no_fwd_b", bus.alu_b, 16'h0456);
    set_fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
`else
    // and r6=r2&r3 while r2 is still in EX/MEM: stall instead of forward.
    set_id(1, 3'd2, 3'd2, 3'd3, 3'd6, 16'h00F0, 16'h0F0F, 16'h0000, 0, 1, 0, 0);
    set_fwd(1, 3'd2, 16'h1234, 0, 3'd0, 16'h0);
    #1;
    check("raw_exmem_lus", bus.load_use_stall, 1);
    tick;
    check("raw_bub_valid",  bus.ex_valid,     0);
    check("raw_bub_a",      bus.alu_a,        0);
    check("raw_bub_b",      bus.alu_b,        0);
    check("raw_bub_opcode", bus.alu_opcode,   0);
    check("raw_bub_rw",     bus.ex_reg_write, 0);
    set_fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    #1;
    check("raw_clear_lus", bus.load_use_stall, 0);
    tick;
    check("and_valid", bus.ex_valid, 1);
    check("and_alu_a", bus.alu_a,    16'h00F0);
    check("and_alu_b", bus.alu_b,    16'h0F0F);
    set_fwd(1, 3'd2, 16'h1234, 1, 3'd2, 16'h2222);
    #1;
    check("nofwd_alu_a", bus.alu_a,         16'h00F0);
    check("nofwd_store", bus.ex_store_data, 16'h0F0F);
    set_fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    set_id(1, 3'd4, 3'd6, 3'd1, 3'd7, 16'h0, 16'h0, 16'h0, 0, 1, 0, 0);
    #1;
    check("raw_ex_rs_lus", bus.load_use_stall, 1);
    set_id(1, 3'd4, 3'd1, 3'd6, 3'd7, 16'h0, 16'h0, 16'h0, 1, 1, 0, 0);
    #1;
    check("raw_ex_imm_lus", bus.load_use_stall, 0);
    set_id(1, 3'd0, 3'd1, 3'd6, 3'd7, 16'h0, 16'h0, 16'h0, 1, 0, 0, 1);
    #1;
    check("raw_ex_store_lus", bus.load_use_stall, 1);
`endif

    // lw r3 <- imm(r1)
    set_id(1, 3'd0, 3'd1, 3'd0, 3'd3, 16'h0010, 16'h0777, 16'h0004, 1, 1, 1, 0);
    #1;
    check("lw_lus", bus.load_use_stall, 0);
    tick;
    check("lw_mem_read", bus.ex_mem_read,   1);
    check("lw_rd",       bus.ex_rd,         3);
    check("lw_alu_a",    bus.alu_a,         16'h0010);
    check("lw_alu_b",    bus.alu_b,         16'h0004);
    check("lw_store",    bus.ex_store_data, 16'h0777);

    set_id(1, 3'd0, 3'd1, 3'd3, 3'd5, 16'h0003, 16'h0030, 16'h0000, 1, 1, 0, 0);
    #1;
    check("lu_imm_lus", bus.load_use_stall, 0);
    set_id(1, 3'd0, 3'd1, 3'd3, 3'd5, 16'h0003, 16'h0030, 16'h0000, 1, 0, 0, 1);
    #1;
    check("lu_store_lus", bus.load_use_stall, 1);
    set_id(1, 3'd0, 3'd3, 3'd1, 3'd5, 16'h0030, 16'h0003, 16'h0000, 0, 1, 0, 0);
    #1;
    check("lu_rs_lus", bus.load_use_stall, 1);
    tick;
    check("lu_bub_valid", bus.ex_valid,      0);
    check("lu_bub_a",     bus.alu_a,         0);
    check("lu_bub_b",     bus.alu_b,         0);
    check("lu_bub_store", bus.ex_store_data, 0);
    check("lu_bub_mr",    bus.ex_mem_read,   0);
    check("lu_after_lus", bus.load_use_stall, 0);
    tick;
    check("add5_valid", bus.ex_valid, 1);
    check("add5_alu_a", bus.alu_a,    16'h0030);
    check("add5_alu_b", bus.alu_b,    16'h0003);
    check("add5_rd",    bus.ex_rd,    5);

    stall = 1'b1;
    set_id(1, 3'd4, 3'd1, 3'd2, 3'd6, 16'hAAAA, 16'hBBBB, 16'h0000, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("stall_valid",  bus.ex_valid,   1);
      check("stall_opcode", bus.alu_opcode, 0);
      check("stall_alu_a",  bus.alu_a,      16'h0030);
      check("stall_alu_b",  bus.alu_b,      16'h0003);
      check("stall_rd",     bus.ex_rd,      5);
    end

    flush = 1'b1;
    tick;
    check("flush_valid", bus.ex_valid,     0);
    check("flush_rd",    bus.ex_rd,        0);
    check("flush_alu_a", bus.alu_a,        0);
    check("flush_rw",    bus.ex_reg_write, 0);

    stall = 1'b0; flush = 1'b0;
    set_id(0, 3'd3, 3'd1, 3'd2, 3'd7, 16'h0001, 16'h0002, 16'h0000, 0, 1, 1, 1);
    tick;
    check("inv_valid",  bus.ex_valid,     0);
    check("inv_rw",     bus.ex_reg_write, 0);
    check("inv_mr",     bus.ex_mem_read,  0);
    check("inv_mw",     bus.ex_mem_write, 0);
    check("inv_opcode", bus.alu_opcode,   0);
    check("inv_rd",     bus.ex_rd,        7);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
